bf_writeback_ctrl: RTL and testbench

- Downstream stage of the Kyber butterfly unit (12-bit coefficients, q=3329).
- Tracks every operation issued to the butterfly through a latency-matched reservation pipeline and selects the correct result port (E/O, ADD/SUB or MUL).
- Drives the two coefficient-bank write ports with aligned address/data.
- Throttles issue so that no two operations retire in the same cycle.

---
 rtl/bf_wb_pkg.sv | 26 ++
 rtl/bf_wb_slot_tracker.sv | 85 ++++++++
 rtl/bf_writeback_ctrl.sv | 140 ++++++++++++++
 tb/tb_bf_writeback_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_wb_pkg.sv
// Shared mode encodings, default latencies and reservation-slot layout
// for the Kyber butterfly write-back controller.
package bf_wb_pkg;

    localparam int WB_ADDR_W = 7;

    localparam logic [2:0] MODE_GS     = 3'd0;
    localparam logic [2:0] MODE_CT     = 3'd1;
    localparam logic [2:0] MODE_ADDSUB = 3'd2;
    localparam logic [2:0] MODE_MUL    = 3'd3;
    localparam logic [2:0] MODE_PWM    = 3'd4;

    localparam int LAT_CT_DEF  = 4;
    localparam int LAT_GS_DEF  = 6;
    localparam int LAT_AS_DEF  = 1;
    localparam int LAT_MUL_DEF = 3;
    localparam int MAX_LAT_DEF = 6;

    typedef struct packed {
        logic                 valid;
        logic [2:0]           mode;
        logic [WB_ADDR_W-1:0] addr_e;
        logic [WB_ADDR_W-1:0] addr_o;
    } slot_t;

endpackage

// File: rtl/bf_wb_slot_tracker.sv
// Latency-matched reservation shift register: slot k moves to k-1 each cycle.
// With WB_HAZARD_EN defined it also flags in-flight destinations being read.
module bf_wb_slot_tracker
    import bf_wb_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LW      = $clog2(MAX_LAT + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LW-1:0]        lat_i,
    input  logic                 ins_i,
    input  slot_t                ent_i,
`ifdef WB_HAZARD_EN
    input  logic [WB_ADDR_W-1:0] rd_a_i,
    input  logic [WB_ADDR_W-1:0] rd_b_i,
    output logic                 hazard_o,
`endif
    output logic                 free_o,
    output logic                 busy_o,
    output slot_t                ret_o
);

    slot_t [MAX_LAT:1] slot_q;
    slot_t [MAX_LAT:1] slot_d;

    // Slot L+1 shifts into slot L on this edge; latency MAX_LAT never collides.
    always_comb begin
        free_o = 1'b1;
        for (int k = 2; k <= MAX_LAT; k++) begin
            if (int'(lat_i) + 1 == k && slot_q[k].valid) begin
                free_o = 1'b0;
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            busy_o = busy_o | slot_q[k].valid;
        end
    end

`ifdef WB_HAZARD_EN
    always_comb begin
        hazard_o = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (slot_q[k].valid) begin
                if (slot_q[k].addr_e == rd_a_i ||
                    slot_q[k].addr_e == rd_b_i) begin
                    hazard_o = 1'b1;
                end
                if (slot_q[k].mode != MODE_MUL &&
                    (slot_q[k].addr_o == rd_a_i ||
                     slot_q[k].addr_o == rd_b_i)) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        for (int k = 1; k < MAX_LAT; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[MAX_LAT] = '0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (ins_i && int'(lat_i) == k) begin
                slot_d[k] = ent_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign ret_o = slot_q[1];

endmodule

// File: rtl/bf_writeback_ctrl.sv
// Butterfly write-back: issue throttling, result-port select, bank writes.
// Optional read-after-write issue hazard check enabled by WB_HAZARD_EN.
module bf_writeback_ctrl
    import bf_wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int LAT_CT  = LAT_CT_DEF,
    parameter int LAT_GS  = LAT_GS_DEF,
    parameter int LAT_AS  = LAT_AS_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_mode,
    input  logic [ADDR_W-1:0] issue_addr_e,
    input  logic [ADDR_W-1:0] issue_addr_o,
`ifdef WB_HAZARD_EN
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
`endif
    input  logic [11:0]       bf_E,
    input  logic [11:0]       bf_O,
    input  logic [11:0]       bf_MUL,
    input  logic [11:0]       bf_ADD,
    input  logic [11:0]       bf_SUB,
    output logic              wr_en_e,
    output logic [ADDR_W-1:0] wr_addr_e,
    output logic [11:0]       wr_data_e,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [11:0]       wr_data_o,
    output logic              busy,
    output logic [15:0]       retire_cnt
);

    localparam int LW = $clog2(MAX_LAT + 2);

    logic [LW-1:0] lat;
    logic          rsvd;
    logic          free;
    logic          hazard;
    logic          ins;
    slot_t         ent;
    slot_t         ret;

    logic              en_e_q, en_o_q;
    logic [ADDR_W-1:0] addr_e_q, addr_o_q;
    logic [11:0]       data_e_q, data_o_q;
    logic [15:0]       cnt_q;

    always_comb begin
        lat  = LW'(LAT_CT);
        rsvd = 1'b0;
        case (issue_mode)
            MODE_GS:           lat = LW'(LAT_GS);
            MODE_CT, MODE_PWM: lat = LW'(LAT_CT);
            MODE_ADDSUB:       lat = LW'(LAT_AS);
            MODE_MUL:          lat = LW'(LAT_MUL);
            default:           rsvd = 1'b1;
        endcase
    end

    assign ent = '{valid:  1'b1,
                   mode:   issue_mode,
                   addr_e: issue_addr_e,
                   addr_o: issue_addr_o};

    assign issue_ready = rst_n & ~rsvd & free & ~hazard;
    assign ins         = issue_valid & issue_ready;

    bf_wb_slot_tracker #(
        .MAX_LAT (MAX_LAT),
        .LW      (LW)
    ) u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .lat_i    (lat),
        .ins_i    (ins),
        .ent_i    (ent),
`ifdef WB_HAZARD_EN
        .rd_a_i   (rd_addr_a),
        .rd_b_i   (rd_addr_b),
        .hazard_o (hazard),
`endif
        .free_o   (free),
        .busy_o   (busy),
        .ret_o    (ret)
    );

`ifndef WB_HAZARD_EN
    assign hazard = 1'b0;
`endif

    // Result ports are valid in the retire cycle; capture them here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_e_q   <= 1'b0;
            en_o_q   <= 1'b0;
            addr_e_q <= '0;
            addr_o_q <= '0;
            data_e_q <= '0;
            data_o_q <= '0;
            cnt_q    <= '0;
        end else begin
            en_e_q <= ret.valid;
            en_o_q <= ret.valid && (ret.mode != MODE_MUL);
            if (ret.valid) begin
                cnt_q    <= cnt_q + 16'd1;
                addr_e_q <= ret.addr_e;
                case (ret.mode)
                    MODE_ADDSUB: begin
                        data_e_q <= bf_ADD;
                        data_o_q <= bf_SUB;
                        addr_o_q <= ret.addr_o;
                    end
                    MODE_MUL: begin
                        data_e_q <= bf_MUL;
                    end
                    default: begin
                        data_e_q <= bf_E;
                        data_o_q <= bf_O;
                        addr_o_q <= ret.addr_o;
                    end
                endcase
            end
        end
    end

    assign wr_en_e    = en_e_q;
    assign wr_en_o    = en_o_q;
    assign wr_addr_e  = addr_e_q;
    assign wr_addr_o  = addr_o_q;
    assign wr_data_e  = data_e_q;
    assign wr_data_o  = data_o_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_bf_writeback_ctrl.sv
// Self-checking bench for bf_writeback_ctrl: directed cases plus random
// traffic against a retire-time model. Hazard cases need WB_HAZARD_EN.
module tb_bf_writeback_ctrl;
    import bf_wb_pkg::*;

    localparam int AW = 7;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    issue_mode;
    logic [AW-1:0] issue_addr_e, issue_addr_o;
    logic [11:0]   bf_E, bf_O, bf_MUL, bf_ADD, bf_SUB;
    logic          wr_en_e, wr_en_o;
    logic [AW-1:0] wr_addr_e, wr_addr_o;
    logic [11:0]   wr_data_e, wr_data_o;
    logic          busy;
    logic [15:0]   retire_cnt;
`ifdef WB_HAZARD_EN
    logic [AW-1:0] rd_addr_a, rd_addr_b;
`endif

    always #5 clk = ~clk;

    bf_writeback_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_mode   (issue_mode),
        .issue_addr_e (issue_addr_e),
        .issue_addr_o (issue_addr_o),
`ifdef WB_HAZARD_EN
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
`endif
        .bf_E         (bf_E),
        .bf_O         (bf_O),
        .bf_MUL       (bf_MUL),
        .bf_ADD       (bf_ADD),
        .bf_SUB       (bf_SUB),
        .wr_en_e      (wr_en_e),
        .wr_addr_e    (wr_addr_e),
        .wr_data_e    (wr_data_e),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy         (busy),
        .retire_cnt   (retire_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: each accepted op is remembered with the edge number it retires on.
    typedef struct {
        int     mode;
        int     ae;
        int     ao;
        longint ret;
    } op_t;

    op_t     q[$];
    longint  edge_n = 0;
    logic          ex_en_e = 0, ex_en_o = 0;
    logic [AW-1:0] ex_ae = 0, ex_ao = 0;
    logic [11:0]   ex_de = 0, ex_do = 0;
    logic [15:0]   ex_cnt = 0;

    function automatic int lat_of(input int m);
        case (m)
            0:       return 6;
            1, 4:    return 4;
            2:       return 1;
            3:       return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit model_ready();
        int L;
        L = lat_of(int'(issue_mode));
        if (!rst_n || L < 0) return 1'b0;
        foreach (q[i]) begin
            if (q[i].ret == edge_n + 1 + L) return 1'b0;
`ifdef WB_HAZARD_EN
            if (q[i].ae == int'(rd_addr_a) || q[i].ae == int'(rd_addr_b))
                return 1'b0;
            if (q[i].mode != 3 &&
                (q[i].ao == int'(rd_addr_a) || q[i].ao == int'(rd_addr_b)))
                return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    function automatic void retire_op(input op_t op);
        ex_cnt  = ex_cnt + 16'd1;
        ex_en_e = 1'b1;
        ex_ae   = AW'(op.ae);
        if (op.mode == 3) begin
            ex_de = bf_MUL;
        end else begin
            ex_en_o = 1'b1;
            ex_ao   = AW'(op.ao);
            ex_de   = (op.mode == 2) ? bf_ADD : bf_E;
            ex_do   = (op.mode == 2) ? bf_SUB : bf_O;
        end
    endfunction

    function automatic void model_clear();
        q.delete();
        ex_en_e = 0; ex_en_o = 0;
        ex_ae = 0; ex_ao = 0;
        ex_de = 0; ex_do = 0;
        ex_cnt = 0;
    endfunction

    initial begin
        bit acc;
        int lat;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                acc = issue_valid && model_ready();
                lat = lat_of(int'(issue_mode));
                edge_n++;
                ex_en_e = 1'b0;
                ex_en_o = 1'b0;
                foreach (q[i]) if (q[i].ret == edge_n) retire_op(q[i]);
                if (acc)
                    q.push_back('{int'(issue_mode), int'(issue_addr_e),
                                  int'(issue_addr_o), edge_n + lat});
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].ret <= edge_n) q.delete(i);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_clear();
                chk("rst_ready", 32'(issue_ready), 0);
                chk("rst_en", 32'({wr_en_e, wr_en_o}), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_cnt", 32'(retire_cnt), 0);
            end else begin
                chk("ready", 32'(issue_ready), 32'(model_ready()));
                chk("busy", 32'(busy), 32'(q.size() != 0));
                chk("en_e", 32'(wr_en_e), 32'(ex_en_e));
                chk("en_o", 32'(wr_en_o), 32'(ex_en_o));
                chk("addr_e", 32'(wr_addr_e), 32'(ex_ae));
                chk("addr_o", 32'(wr_addr_o), 32'(ex_ao));
                chk("data_e", 32'(wr_data_e), 32'(ex_de));
                chk("data_o", 32'(wr_data_o), 32'(ex_do));
                chk("cnt", 32'(retire_cnt), 32'(ex_cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        issue_valid = 0; issue_mode = 0;
        issue_addr_e = 0; issue_addr_o = 0;
        bf_E = 0; bf_O = 0; bf_MUL = 0; bf_ADD = 0; bf_SUB = 0;
`ifdef WB_HAZARD_EN
        rd_addr_a = 7'h3F; rd_addr_b = 7'h3F;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // CT stream: op k retires at the end of cycle k+4
        for (int c = 0; c < 13; c++) begin
            issue_valid  = (c < 8);
            issue_mode   = MODE_CT;
            issue_addr_e = AW'(c);
            issue_addr_o = AW'(c + 64);
            bf_E = 12'(c + 96);
            bf_O = 12'(c + 600);
            #1;
            if (c < 8) chk("ct_ready", 32'(issue_ready), 1);
            tick();
            if (c >= 4 && c < 12) begin
                chk("ct_en", 32'({wr_en_e, wr_en_o}), 3);
                chk("ct_addr_e", 32'(wr_addr_e), c - 4);
                chk("ct_addr_o", 32'(wr_addr_o), c - 4 + 64);
                chk("ct_data_e", 32'(wr_data_e), c - 4 + 100);
            end
        end
        chk("ct_cnt", 32'(retire_cnt), 8);

        // Reset with three CT ops in flight
        for (int c = 0; c < 3; c++) begin
            issue_valid  = 1'b1;
            issue_mode   = MODE_CT;
            issue_addr_e = AW'(c + 8);
            issue_addr_o = AW'(c + 72);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cnt", 32'(retire_cnt), 0);
        chk("mid_rst_ready", 32'(issue_ready), 0);
        chk("mid_rst_data", 32'({wr_data_e, wr_data_o}), 0);
        chk("mid_rst_addr", 32'({wr_addr_e, wr_addr_o}), 0);
        issue_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(8);
        chk("post_rst_cnt", 32'(retire_cnt), 0);

        // GS then colliding ADDSUB
        bf_E = 12'd11; bf_O = 12'd22; bf_ADD = 12'd5; bf_SUB = 12'd3324;
        for (int c = 0; c < 9; c++) begin
            issue_valid  = (c == 0) || (c == 5) || (c == 6);
            issue_mode   = (c == 0) ? MODE_GS : MODE_ADDSUB;
            issue_addr_e = (c == 0) ? 7'h20 : 7'h21;
            issue_addr_o = (c == 0) ? 7'h30 : 7'h31;
            #1;
            if (c == 5) chk("col_stall", 32'(issue_ready), 0);
            if (c == 6) chk("col_accept", 32'(issue_ready), 1);
            tick();
            if (c == 6) begin
                chk("gs_data_e", 32'(wr_data_e), 11);
                chk("gs_data_o", 32'(wr_data_o), 22);
                chk("gs_addr_e", 32'(wr_addr_e), 32'h20);
            end
            if (c == 7) begin
                chk("as_data_e", 32'(wr_data_e), 5);
                chk("as_data_o", 32'(wr_data_o), 3324);
                chk("as_addr_o", 32'(wr_addr_o), 32'h31);
            end
        end

        // MUL: bank O untouched
        bf_MUL = 12'd3328;
        for (int c = 0; c < 5; c++) begin
            issue_valid  = (c == 0);
            issue_mode   = MODE_MUL;
            issue_addr_e = 7'h7F;
            issue_addr_o = 7'h11;
            tick();
            if (c == 3) begin
                chk("mul_en", 32'({wr_en_e, wr_en_o}), 2);
                chk("mul_addr_e", 32'(wr_addr_e), 32'h7F);
                chk("mul_data_e", 32'(wr_data_e), 3328);
                chk("mul_addr_o_hold", 32'(wr_addr_o), 32'h31);
            end
        end

        // PWM uses the CT latency
        bf_E = 12'd77; bf_O = 12'd88;
        for (int c = 0; c < 6; c++) begin
            issue_valid  = (c == 0);
            issue_mode   = MODE_PWM;
            issue_addr_e = 7'h05;
            issue_addr_o = 7'h45;
            tick();
            if (c == 4) begin
                chk("pwm_en", 32'({wr_en_e, wr_en_o}), 3);
                chk("pwm_data", 32'({wr_data_e, wr_data_o}),
                    32'({12'd77, 12'd88}));
            end
        end

        // Reserved mode is never accepted
        for (int c = 0; c < 10; c++) begin
            issue_valid = 1'b1;
            issue_mode  = 3'd5 + 3'(c % 3);
            #1;
            chk("rsvd_ready", 32'(issue_ready), 0);
            tick();
        end
        idle(8);
        chk("rsvd_cnt", 32'(retire_cnt), 4);
        chk("rsvd_en", 32'({wr_en_e, wr_en_o}), 0);

`ifdef WB_HAZARD_EN
        for (int c = 0; c < 7; c++) begin
            issue_valid  = 1'b1;
            issue_mode   = MODE_CT;
            issue_addr_e = (c == 0) ? 7'h10 : 7'h12;
            issue_addr_o = (c == 0) ? 7'h50 : 7'h52;
            rd_addr_a    = (c == 0) ? 7'h3F : 7'h10;
            #1;
            if (c >= 1 && c <= 4) chk("haz_stall", 32'(issue_ready), 0);
            if (c == 5) chk("haz_clear", 32'(issue_ready), 1);
            tick();
            if (c == 5) issue_valid = 1'b0;
        end
        rd_addr_a = 7'h3F;
        idle(8);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            issue_valid  = ($urandom_range(0, 9) < 7);
            issue_mode   = 3'($urandom_range(0, 7));
            issue_addr_e = AW'($urandom);
            issue_addr_o = AW'($urandom);
            bf_E   = 12'($urandom_range(0, 3328));
            bf_O   = 12'($urandom_range(0, 3328));
            bf_MUL = 12'($urandom_range(0, 3328));
            bf_ADD = 12'($urandom_range(0, 3328));
            bf_SUB = 12'($urandom_range(0, 3328));
`ifdef WB_HAZARD_EN
            rd_addr_a = AW'($urandom);
            rd_addr_b = AW'($urandom);
`endif
            tick();
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
